// File: rtl/addr_gen_pkg.sv
// addr_gen_pkg: shared definitions for the 6502 effective-address generator.
//   - ADDR_WIDTH / REG_WIDTH : machine address and register widths
//   - AM_*                   : 4-bit addressing-mode encodings seen on 'mode'
//   - ag_state_e             : sequencer states of addr_gen
package addr_gen_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int REG_WIDTH  = 8;

  localparam logic [3:0] AM_ZPG  = 4'd0;
  localparam logic [3:0] AM_ZPGX = 4'd1;
  localparam logic [3:0] AM_ZPGY = 4'd2;
  localparam logic [3:0] AM_ABS  = 4'd3;
  localparam logic [3:0] AM_ABSX = 4'd4;
  localparam logic [3:0] AM_ABSY = 4'd5;
  localparam logic [3:0] AM_INDX = 4'd6;
  localparam logic [3:0] AM_INDY = 4'd7;
  localparam logic [3:0] AM_IND  = 4'd8;

  typedef enum logic [2:0] {
    AG_IDLE  = 3'd0,
    AG_RD_LO = 3'd1,
    AG_RD_HI = 3'd2,
    AG_CALC  = 3'd3,
    AG_DONE  = 3'd4
  } ag_state_e;

  // True for the modes that need two zero-page / absolute pointer reads.
  function automatic logic is_indirect(input logic [3:0] m);
    return (m == AM_INDX) || (m == AM_INDY) || (m == AM_IND);
  endfunction

endpackage

// File: rtl/addr_gen.sv
// addr_gen: effective-address generator for the 6502 addressing modes.
//
// Direct modes (ZPG/ZPGX/ZPGY/ABS/ABSX/ABSY, reserved codes 9-15 as ABS)
// finish one cycle after start. Indirect modes (INDX/INDY/IND) read the
// pointer low and high bytes through mem_addr/mem_rd and finish four cycles
// after start. A single adder is shared by all states.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, mode           request (sampled only in IDLE) and AM_* mode
//   op_lo, op_hi          operand bytes
//   x_in, y_in            index register values
//   mem_rdata             pointer read data, valid the cycle after mem_rd
//   mem_addr, mem_rd      pointer read address/strobe (address held when idle)
//   eff_addr              effective address, valid with done, held afterwards
//   done                  one-cycle completion pulse
//   busy                  high whenever the sequencer is not IDLE
//   page_cross            low-byte carry of the ABSX/ABSY/INDY index add
//
// Build option: NES_JMP_IND_BUG_EN makes the IND high-byte pointer wrap
// inside its page (NMOS behaviour) instead of incrementing across it.
module addr_gen
  import addr_gen_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = REG_WIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        mode,
  input  logic [DATA_W-1:0] op_lo,
  input  logic [DATA_W-1:0] op_hi,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] eff_addr,
  output logic              done,
  output logic              busy,
  output logic              page_cross
);

  localparam int HI_W = ADDR_W - DATA_W;

  // Zero-extend a byte into the zero page.
  function automatic logic [ADDR_W-1:0] zp(input logic [DATA_W-1:0] b);
    return {{HI_W{1'b0}}, b};
  endfunction

  ag_state_e         state_r;
  logic [3:0]        mode_r;
  logic [DATA_W-1:0] y_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [DATA_W-1:0] lo_r;

  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_rd_r;
  logic [ADDR_W-1:0] eff_addr_r;
  logic              done_r;
  logic              busy_r;
  logic              page_cross_r;

  logic [ADDR_W-1:0] add_a_s;
  logic [ADDR_W-1:0] add_b_s;
  logic [ADDR_W-1:0] sum_s;
  logic              lo_carry_s;
  logic [ADDR_W-1:0] zp_sum_s;
  logic [ADDR_W-1:0] ptr_s;
  logic [ADDR_W-1:0] ptr1_s;
  logic [ADDR_W-1:0] dir_eff_s;
  logic              dir_pc_s;

  // Shared adder operand selection: mode decode in IDLE, pointer increment
  // in RD_LO, final {hi,lo}(+Y) in CALC.
  always_comb begin
    add_a_s = {ADDR_W{1'b0}};
    add_b_s = {ADDR_W{1'b0}};
    case (state_r)
      AG_IDLE: begin
        case (mode)
          AM_ZPG, AM_INDY: begin
            add_a_s = zp(op_lo);
          end
          AM_ZPGX, AM_INDX: begin
            add_a_s = zp(op_lo);
            add_b_s = zp(x_in);
          end
          AM_ZPGY: begin
            add_a_s = zp(op_lo);
            add_b_s = zp(y_in);
          end
          AM_ABSX: begin
            add_a_s = {op_hi, op_lo};
            add_b_s = zp(x_in);
          end
          AM_ABSY: begin
            add_a_s = {op_hi, op_lo};
            add_b_s = zp(y_in);
          end
          default: begin
            // ABS, IND and reserved codes use the operand as-is.
            add_a_s = {op_hi, op_lo};
          end
        endcase
      end
      AG_RD_LO: begin
        add_a_s = ptr_r;
        add_b_s = {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      AG_CALC: begin
        add_a_s = {mem_rdata, lo_r};
        if (mode_r == AM_INDY) begin
          add_b_s = zp(y_r);
        end else begin
          add_b_s = {ADDR_W{1'b0}};
        end
      end
      default: begin
        add_a_s = {ADDR_W{1'b0}};
        add_b_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  assign sum_s      = add_a_s + add_b_s;
  // Carry into bit DATA_W recovered from the sum, so no second adder is needed.
  assign lo_carry_s = sum_s[DATA_W] ^ add_a_s[DATA_W] ^ add_b_s[DATA_W];
  assign zp_sum_s   = zp(sum_s[DATA_W-1:0]);

  // First pointer address and direct-mode result decoded from the IDLE sum.
  always_comb begin
    ptr_s     = zp_sum_s;
    dir_eff_s = sum_s;
    dir_pc_s  = 1'b0;
    if (mode == AM_IND) begin
      ptr_s = sum_s;
    end else begin
      ptr_s = zp_sum_s;
    end
    case (mode)
      AM_ZPG, AM_ZPGX, AM_ZPGY: begin
        dir_eff_s = zp_sum_s;
      end
      AM_ABSX, AM_ABSY: begin
        dir_pc_s = lo_carry_s;
      end
      default: begin
        dir_eff_s = sum_s;
        dir_pc_s  = 1'b0;
      end
    endcase
  end

  // Second pointer address: zero-page wrap for INDX/INDY, IND per build option.
  always_comb begin
    ptr1_s = zp_sum_s;
    if (mode_r == AM_IND) begin
`ifdef NES_JMP_IND_BUG_EN
      ptr1_s = {ptr_r[ADDR_W-1:DATA_W], sum_s[DATA_W-1:0]};
`else
      ptr1_s = sum_s;
`endif
    end else begin
      ptr1_s = zp_sum_s;
    end
  end

  // Sequencer with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= AG_IDLE;
      mode_r       <= 4'd0;
      y_r          <= {DATA_W{1'b0}};
      ptr_r        <= {ADDR_W{1'b0}};
      lo_r         <= {DATA_W{1'b0}};
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_rd_r     <= 1'b0;
      eff_addr_r   <= {ADDR_W{1'b0}};
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      page_cross_r <= 1'b0;
    end else begin
      case (state_r)
        AG_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            mode_r <= mode;
            y_r    <= y_in;
            busy_r <= 1'b1;
            if (is_indirect(mode)) begin
              ptr_r      <= ptr_s;
              mem_addr_r <= ptr_s;
              mem_rd_r   <= 1'b1;
              state_r    <= AG_RD_LO;
            end else begin
              eff_addr_r   <= dir_eff_s;
              page_cross_r <= dir_pc_s;
              done_r       <= 1'b1;
              state_r      <= AG_DONE;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        AG_RD_LO: begin
          mem_addr_r <= ptr1_s;
          mem_rd_r   <= 1'b1;
          state_r    <= AG_RD_HI;
        end
        AG_RD_HI: begin
          lo_r     <= mem_rdata;
          mem_rd_r <= 1'b0;
          state_r  <= AG_CALC;
        end
        AG_CALC: begin
          // mem_rdata carries the high pointer byte in this cycle.
          eff_addr_r   <= sum_s;
          page_cross_r <= (mode_r == AM_INDY) ? lo_carry_s : 1'b0;
          done_r       <= 1'b1;
          state_r      <= AG_DONE;
        end
        AG_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= AG_IDLE;
        end
        default: begin
          done_r   <= 1'b0;
          busy_r   <= 1'b0;
          mem_rd_r <= 1'b0;
          state_r  <= AG_IDLE;
        end
      endcase
    end
  end

  assign mem_addr   = mem_addr_r;
  assign mem_rd     = mem_rd_r;
  assign eff_addr   = eff_addr_r;
  assign done       = done_r;
  assign busy       = busy_r;
  assign page_cross = page_cross_r;

endmodule
